f1_launch_ctrl: RTL and testbench

Launch controller for the F1 start-lights stage. It paces the 8-light ramp FSM by issuing one-cycle step enables at a programmable tick rate. After the FSM reports all lights on (8'hFF), it holds for a pseudo-random number of ticks and then steps the FSM once more, so the lights go out. It then measures the driver's reaction time in clock cycles, and flags a jump start if the driver reacts before lights-out.

---
 rtl/f1_launch_ctrl.sv | 126 ++++++++++++
 tb/tb_f1_launch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/f1_launch_ctrl.sv
// F1 start-lights launch controller: paces the light ramp, holds for a random
// number of ticks, turns the lights out, then times the driver's reaction.
module f1_launch_ctrl #(
  parameter int unsigned TICK_N = 48,
  parameter int unsigned TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              react,
  input  logic [7:0]        lights_in,
  output logic              fsm_en,
  output logic              fsm_rst,
  output logic              busy,
  output logic              time_valid,
  output logic [TIME_W-1:0] reaction_time,
  output logic              jump_start
);

  localparam int unsigned CNT_W = $clog2(TICK_N);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_N - 1);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, GO} state_t;

  state_t            state, state_next;
  logic [6:0]        lfsr;
  logic [CNT_W-1:0]  tick_cnt;
  logic [4:0]        hold_ticks;
  logic [TIME_W-1:0] react_cnt;

  logic tick, all_on, last_hold;
  logic fsm_en_d, fsm_rst_d, time_valid_d, jump_d;

  assign tick      = (tick_cnt == '0);
  assign all_on    = (lights_in == 8'hFF);
  assign last_hold = tick && (hold_ticks == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= 7'h01;
      tick_cnt      <= TICK_LAST;
      hold_ticks    <= '0;
      react_cnt     <= '0;
      fsm_en        <= 1'b0;
      fsm_rst       <= 1'b0;
      busy          <= 1'b0;
      time_valid    <= 1'b0;
      jump_start    <= 1'b0;
      reaction_time <= '0;
    end else begin
      state <= state_next;
      lfsr  <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};

      if ((state_next != state) || tick)
        tick_cnt <= TICK_LAST;
      else
        tick_cnt <= tick_cnt - CNT_W'(1);

      if ((state == RAMP) && (state_next == HOLD))
        hold_ticks <= {1'b0, lfsr[3:0]} + 5'd1;
      else if ((state == HOLD) && tick)
        hold_ticks <= hold_ticks - 5'd1;

      // Only cycles with the lights actually out are counted; stop at all-ones.
      if ((state == HOLD) && (state_next == GO))
        react_cnt <= '0;
      else if ((state == GO) && !react && (lights_in == 8'h00) && (react_cnt != '1))
        react_cnt <= react_cnt + TIME_W'(1);

      if (time_valid_d)
        reaction_time <= react_cnt;

      fsm_en     <= fsm_en_d;
      fsm_rst    <= fsm_rst_d;
      busy       <= (state_next != IDLE);
      time_valid <= time_valid_d;
      jump_start <= jump_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (trigger) state_next = RAMP;
      RAMP: begin
        if (react)       state_next = IDLE;
        else if (all_on) state_next = HOLD;
      end
      HOLD: begin
        if (react)          state_next = IDLE;
        else if (last_hold) state_next = GO;
      end
      GO:   if (react) state_next = IDLE;
    endcase
  end

  // A jump start suppresses any step enable due in the same cycle.
  always_comb begin
    fsm_en_d     = 1'b0;
    fsm_rst_d    = 1'b0;
    time_valid_d = 1'b0;
    jump_d       = 1'b0;
    case (state)
      IDLE: fsm_rst_d = trigger;
      RAMP: begin
        if (react) begin
          jump_d    = 1'b1;
          fsm_rst_d = 1'b1;
        end else if (!all_on) begin
          fsm_en_d = tick;
        end
      end
      HOLD: begin
        if (react) begin
          jump_d    = 1'b1;
          fsm_rst_d = 1'b1;
        end else begin
          fsm_en_d = last_hold;
        end
      end
      GO:   time_valid_d = react;
    endcase
  end

endmodule

// File: tb/tb_f1_launch_ctrl.sv
// Directed bench for f1_launch_ctrl paired with a behavioural light-ramp FSM;
// reaction times and jump starts are predicted into queues and popped on output.
module tb_f1_launch_ctrl;
  localparam int unsigned TICK_N = 4;
  localparam int unsigned TIME_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic react = 1'b0;
  logic [7:0] lights_in;
  logic fsm_en, fsm_rst, busy, time_valid, jump_start;
  logic [TIME_W-1:0] reaction_time;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [6:0] m_lfsr = 7'h01;
  int unsigned ramp_s = 0;
  logic [TIME_W-1:0] exp_time_q[$];
  int jump_q[$];

  always #5 clk = ~clk;

  f1_launch_ctrl #(.TICK_N(TICK_N), .TIME_W(TIME_W)) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .react(react),
    .lights_in(lights_in),
    .fsm_en(fsm_en),
    .fsm_rst(fsm_rst),
    .busy(busy),
    .time_valid(time_valid),
    .reaction_time(reaction_time),
    .jump_start(jump_start)
  );

  // Ramp FSM S0..S8 with registered step enable, cleared by rst | fsm_rst.
  always @(posedge clk) begin
    if (rst || fsm_rst) ramp_s <= 0;
    else if (fsm_en)    ramp_s <= (ramp_s == 8) ? 0 : ramp_s + 1;
  end
  assign lights_in = 8'((16'd1 << ramp_s) - 16'd1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (fsm_en) begin
        at = cyc;
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (time_valid) begin
      if (exp_time_q.size() == 0) check("unexpected time_valid", time_valid, 0);
      else check("sb reaction_time", reaction_time, exp_time_q.pop_front());
    end
    if (jump_start) begin
      if (jump_q.size() == 0) check("unexpected jump_start", jump_start, 0);
      else begin
        void'(jump_q.pop_front());
        check("sb jump fsm_rst", fsm_rst, 1);
      end
    end
  end

  initial begin
    int t_prev, t_at, hold_exp, n_rst;
    logic [6:0] lf;

    // Reset
    step(1);
    check("in reset", {fsm_en, fsm_rst, busy, time_valid, jump_start, reaction_time}, 0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("reset idle", {fsm_en, fsm_rst, busy, time_valid, jump_start, reaction_time}, 0);
    end

    // Normal run with an ignored second trigger during RAMP
    trigger = 1'b1; step(1); trigger = 1'b0;
    check("start fsm_rst", fsm_rst, 1);
    check("start busy", busy, 1);
    check("start no en", fsm_en, 0);
    t_prev = cyc;
    n_rst = 0;
    for (int i = 0; i < 8; i++) begin
      wait_en(20, t_at);
      check("ramp cadence", t_at - t_prev, TICK_N);
      t_prev = t_at;
      step(1);
      if (fsm_rst) n_rst++;
      check("ramp lights", lights_in, (1 << (i + 1)) - 1);
      if (i == 2) begin
        trigger = 1'b1; step(1); trigger = 1'b0;
        if (fsm_rst) n_rst++;
      end
    end
    lf = m_lfsr;
    hold_exp = int'(lf[3:0]) + 1;
    wait_en(100, t_at);
    check("hold length", t_at - t_prev, 2 + TICK_N * hold_exp);
    check("go busy", busy, 1);
    step(1);
    check("lights out", lights_in, 0);
    step(10);
    react = 1'b1;
    exp_time_q.push_back(TIME_W'(10));
    step(1);
    react = 1'b0;
    check("measure valid", time_valid, 1);
    check("measure time", reaction_time, 10);
    check("measure busy", busy, 0);
    check("no extra fsm_rst", n_rst, 0);

    // react in IDLE is ignored
    react = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("idle react quiet", {fsm_en, fsm_rst, busy, time_valid, jump_start}, 0);
    end
    react = 1'b0;

    // Jump start during HOLD
    trigger = 1'b1; step(1); trigger = 1'b0;
    for (int i = 0; i < 8; i++) wait_en(20, t_at);
    step(1);
    check("jump lights on", lights_in, 8'hFF);
    step(1);
    check("hold busy", busy, 1);
    react = 1'b1;
    jump_q.push_back(1);
    step(1);
    react = 1'b0;
    check("jump pulse", jump_start, 1);
    check("jump fsm_rst", fsm_rst, 1);
    check("jump no en", fsm_en, 0);
    check("jump no valid", time_valid, 0);
    check("jump keeps time", reaction_time, 10);
    check("jump idle", busy, 0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("post jump quiet", {fsm_en, time_valid, busy, jump_start}, 0);
    end
    check("jump lights cleared", lights_in, 0);

    // Saturation of the reaction counter
    trigger = 1'b1; step(1); trigger = 1'b0;
    for (int i = 0; i < 9; i++) wait_en(100, t_at);
    check("sat reached go", t_at != -1, 1);
    step(300);
    react = 1'b1;
    exp_time_q.push_back('1);
    step(1);
    react = 1'b0;
    check("sat valid", time_valid, 1);
    check("sat time", reaction_time, 8'hFF);

    // Reset in the middle of GO
    trigger = 1'b1; step(1); trigger = 1'b0;
    for (int i = 0; i < 9; i++) wait_en(100, t_at);
    step(5);
    rst = 1'b1;
    step(1);
    check("mid rst outputs", {fsm_en, fsm_rst, busy, time_valid, jump_start, reaction_time}, 0);
    check("mid rst lights", lights_in, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("post rst quiet", {fsm_en, fsm_rst, busy, time_valid, jump_start}, 0);
    end

    check("time sb drained", exp_time_q.size(), 0);
    check("jump sb drained", jump_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
